// File: rtl/imem_loader_if.sv
// Stream-in and instruction-memory write bundle for the program loader.
// The loader connects to the slave modport; the stream source and CPU side use master.
interface imem_loader_if #(
    parameter int DW = 32,
    parameter int AW = 12
);
    logic          start_i;
    logic [AW-2:0] len_i;
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [DW-1:0] imem_wd_o;
    logic          cpu_hold_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    modport slave (
        input  start_i, len_i, byte_i, byte_valid_i,
        output byte_ready_o, imem_we_o, imem_addr_o, imem_wd_o,
        output cpu_hold_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, len_i, byte_i, byte_valid_i,
        input  byte_ready_o, imem_we_o, imem_addr_o, imem_wd_o,
        input  cpu_hold_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a byte-wide program into instruction memory, packing little-endian words,
// and keeps the CPU held until the whole program has been written.
module imem_loader #(
    parameter int DW      = 32,
    parameter int AW      = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    localparam int            DEPTH   = 2 ** (AW - 2);
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [AW-2:0] DEPTH_L = (AW-1)'(DEPTH);
    localparam logic [AW-2:0] ONE_L   = (AW-1)'(1);
    localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t        state;
    state_t        nextState;
    logic [AW-2:0] lenR;
    logic [AW-2:0] wordIdx;
    logic [1:0]    byteCnt;
    logic [TW-1:0] idleCnt;
    logic [DW-1:0] wordR;
    logic          errR;
    logic          accept;
    logic          startOk;

    assign accept  = (state == LOAD) && bus.byte_valid_i;
    assign startOk = bus.start_i && ((state == IDLE) || (state == ERR));

    // Next-state decode; ERR takes a start request exactly like IDLE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, ERR: begin
                if (!startOk) begin
                    nextState = state;
                end else if (bus.len_i == {(AW-1){1'b0}}) begin
                    nextState = DONE;
                end else if (bus.len_i > DEPTH_L) begin
                    nextState = ERR;
                end else begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                if (accept && (byteCnt == 2'd3)) begin
                    nextState = WRITE;
                end else if (!accept && (idleCnt == TLAST)) begin
                    nextState = ERR;
                end else begin
                    nextState = LOAD;
                end
            end
            WRITE: begin
                if (wordIdx == (lenR - ONE_L)) begin
                    nextState = DONE;
                end else begin
                    nextState = LOAD;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Word assembly, word index and inter-byte idle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lenR    <= {(AW-1){1'b0}};
            wordIdx <= {(AW-1){1'b0}};
            byteCnt <= 2'd0;
            idleCnt <= {TW{1'b0}};
            wordR   <= {DW{1'b0}};
        end else begin
            case (state)
                IDLE, ERR: begin
                    if (startOk) begin
                        lenR    <= bus.len_i;
                        wordIdx <= {(AW-1){1'b0}};
                        byteCnt <= 2'd0;
                        idleCnt <= {TW{1'b0}};
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wordR[{byteCnt, 3'b000} +: 8] <= bus.byte_i;
                        byteCnt <= byteCnt + 2'd1;
                        idleCnt <= {TW{1'b0}};
                    end else begin
                        idleCnt <= idleCnt + 1'b1;
                    end
                end
                WRITE: begin
                    wordIdx <= wordIdx + ONE_L;
                    idleCnt <= {TW{1'b0}};
                end
                default: begin
                    idleCnt <= idleCnt;
                end
            endcase
        end
    end

    // Sticky error: a start decides it fresh, a timeout sets it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errR <= 1'b0;
        end else if (startOk) begin
            errR <= (nextState == ERR);
        end else if (nextState == ERR) begin
            errR <= 1'b1;
        end else begin
            errR <= errR;
        end
    end

    assign bus.byte_ready_o = (state == LOAD);
    assign bus.imem_we_o    = (state == WRITE);
    assign bus.imem_addr_o  = {wordIdx[AW-3:0], 2'b00};
    assign bus.imem_wd_o    = wordR;
    assign bus.cpu_hold_o   = (state == LOAD) || (state == WRITE) || (state == ERR);
    assign bus.busy_o       = (state == LOAD) || (state == WRITE);
    assign bus.done_o       = (state == DONE);
    assign bus.err_o        = errR;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and retired by a monitor watching the imem write port.
module tb_imem_loader;
    localparam int DW      = 32;
    localparam int AW      = 12;
    localparam int TIMEOUT = 1024;
    localparam int DEPTH   = 2 ** (AW - 2);

    logic clk;
    logic rst;
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   writeCount  = 0;
    logic [AW-1:0] lastAddr;
    logic [AW+DW-1:0] expQ[$];

    imem_loader_if #(.DW(DW), .AW(AW)) bus();

    imem_loader #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && bus.imem_we_o) begin
            logic [AW+DW-1:0] e;
            writeCount++;
            lastAddr = bus.imem_addr_o;
            if (expQ.size() == 0) begin
                checkVal("unexpected_write", 64'(bus.imem_addr_o), 64'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkVal("wr_addr", 64'(bus.imem_addr_o), 64'(e[AW+DW-1:DW]));
                checkVal("wr_data", 64'(bus.imem_wd_o), 64'(e[DW-1:0]));
            end
        end
    end

    function automatic logic [63:0] outsVec();
        return 64'({bus.byte_ready_o, bus.imem_we_o, bus.imem_addr_o, bus.imem_wd_o,
                    bus.cpu_hold_o, bus.busy_o, bus.done_o, bus.err_o});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doStart(input int len);
        bus.start_i = 1'b1;
        bus.len_i   = (AW-1)'(len);
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int   n;
        logic acc;
        bus.byte_valid_i = 1'b0;
        repeat (gap) tick();
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            acc = bus.byte_ready_o;
            tick();
            n++;
        end
        bus.byte_valid_i = 1'b0;
        if (!acc) checkVal("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic sendWord(input int idx, input logic [31:0] data, input int maxGap);
        expQ.push_back({AW'(idx << 2), data});
        for (int k = 0; k < 4; k++) begin
            sendByte(data[8*k +: 8], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
        end
    endtask

    task automatic waitDone();
        int n = 0;
        while (!bus.done_o && n < 100) begin
            tick();
            n++;
        end
        checkVal("done_seen", 64'(bus.done_o), 64'd1);
    endtask

    initial begin
        int base;
        rst              = 1'b0;
        bus.start_i      = 1'b0;
        bus.len_i        = '0;
        bus.byte_i       = 8'd0;
        bus.byte_valid_i = 1'b0;
        #1;
        checkVal("reset_outputs", outsVec(), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();

        // T1 single word
        base = writeCount;
        doStart(1);
        checkVal("t1_busy", 64'(bus.busy_o), 64'd1);
        sendWord(0, 32'h0000_0013, 0);
        checkVal("t1_we", 64'(bus.imem_we_o), 64'd1);
        tick();
        checkVal("t1_done", 64'(bus.done_o), 64'd1);
        checkVal("t1_hold", 64'(bus.cpu_hold_o), 64'd0);
        tick();
        checkVal("t1_done_pulse", 64'(bus.done_o), 64'd0);
        checkVal("t1_writes", 64'(writeCount - base), 64'd1);

        // T2 three words with random gaps
        base = writeCount;
        doStart(3);
        for (int w = 0; w < 3; w++) sendWord(w, $urandom, 3);
        waitDone();
        checkVal("t2_writes", 64'(writeCount - base), 64'd3);
        checkVal("t2_queue", 64'(expQ.size()), 64'd0);

        // T3 edge lengths
        base = writeCount;
        tick();
        doStart(0);
        checkVal("t3_len0_done", 64'(bus.done_o), 64'd1);
        checkVal("t3_len0_ready", 64'(bus.byte_ready_o), 64'd0);
        tick();
        checkVal("t3_len0_idle", 64'(bus.done_o | bus.byte_ready_o | bus.busy_o), 64'd0);
        doStart(DEPTH + 1);
        checkVal("t3_over_err", 64'(bus.err_o), 64'd1);
        checkVal("t3_over_hold", 64'(bus.cpu_hold_o), 64'd1);
        checkVal("t3_over_ready", 64'(bus.byte_ready_o), 64'd0);
        repeat (3) tick();
        checkVal("t3_err_sticky", 64'(bus.err_o), 64'd1);
        checkVal("t3_writes", 64'(writeCount - base), 64'd0);

        // T4 timeout after one full word and two bytes
        base = writeCount;
        doStart(2);
        checkVal("t4_err_cleared", 64'(bus.err_o), 64'd0);
        sendWord(0, 32'hA1B2_C3D4, 0);
        sendByte(8'h55, 0);
        sendByte(8'h66, 0);
        repeat (TIMEOUT - 1) tick();
        checkVal("t4_not_yet_err", 64'(bus.err_o), 64'd0);
        checkVal("t4_still_busy", 64'(bus.busy_o), 64'd1);
        tick();
        checkVal("t4_err", 64'(bus.err_o), 64'd1);
        checkVal("t4_err_hold", 64'(bus.cpu_hold_o), 64'd1);
        checkVal("t4_writes", 64'(writeCount - base), 64'd1);
        base = writeCount;
        doStart(1);
        checkVal("t4_restart_err", 64'(bus.err_o), 64'd0);
        sendWord(0, 32'h0BAD_F00D, 0);
        waitDone();
        checkVal("t4_reload_writes", 64'(writeCount - base), 64'd1);

        // T5 asynchronous reset mid-load
        base = writeCount;
        tick();
        doStart(1);
        sendByte(8'hEE, 0);
        sendByte(8'hDD, 0);
        #2 rst = 1'b0;
        #1;
        checkVal("t5_async_reset", outsVec(), 64'd0);
        @(negedge clk) rst = 1'b1;
        tick();
        checkVal("t5_no_write", 64'(writeCount - base), 64'd0);
        doStart(1);
        sendWord(0, 32'h1234_5678, 1);
        waitDone();
        checkVal("t5_writes", 64'(writeCount - base), 64'd1);

        // T6 start ignored during LOAD
        base = writeCount;
        tick();
        doStart(2);
        expQ.push_back({AW'(0), 32'hCAFE_BABE});
        sendByte(8'hBE, 0);
        sendByte(8'hBA, 0);
        doStart(5);
        sendByte(8'hFE, 0);
        sendByte(8'hCA, 0);
        sendWord(1, 32'h8765_4321, 0);
        waitDone();
        checkVal("t6_writes", 64'(writeCount - base), 64'd2);
        repeat (3) tick();
        checkVal("t6_idle", 64'(bus.busy_o), 64'd0);

        // Full-depth load: last word lands at (DEPTH-1)<<2
        base = writeCount;
        doStart(DEPTH);
        for (int w = 0; w < DEPTH; w++) sendWord(w, $urandom, 0);
        waitDone();
        checkVal("full_writes", 64'(writeCount - base), 64'(DEPTH));
        checkVal("full_last_addr", 64'(lastAddr), 64'((DEPTH - 1) << 2));
        checkVal("full_queue", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
